// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: iterative signed shift-add multiplier / restoring divider that stalls the pipeline while busy.
// Optional build macro MULTDIV_EARLY_OUT_EN: a multiply finishes once its remaining multiplier bits are all zero.
module multdiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic             flush,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic [4:0]       dest_reg,
    output logic             stall,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       result_reg,
    output logic             exception
);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               neg;
    logic               is_div;
    logic               div_ovf;
    logic [4:0]         dest_q;

    logic               take;
    logic               div_zero;
    logic               last_iter;
    logic [WIDTH:0]     rem_shift;
    logic               q_bit;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] mag_a_step;
    logic [WIDTH-1:0]   mag_b_step;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v, input logic s);
        return s ? -v : v;
    endfunction

    // Product overflows unless its top WIDTH+1 bits are a pure sign extension.
    function automatic logic mult_ovf(input logic signed [2*WIDTH-1:0] p);
        return !((&p[2*WIDTH-1:WIDTH-1]) || !(|p[2*WIDTH-1:WIDTH-1]));
    endfunction

    assign take     = (start_mult || start_div) && !flush;
    assign div_zero = start_div && !start_mult && (operandB == '0);

    // Single iteration step: mag_a doubles as multiplicand (mult) or dividend/quotient shifter (div).
    always_comb begin
        rem_shift = {acc[WIDTH-1:0], mag_a[WIDTH-1]};
        q_bit     = rem_shift >= {1'b0, mag_b};
        if (is_div) begin
            acc_step   = q_bit ? {{(WIDTH-1){1'b0}}, rem_shift - {1'b0, mag_b}}
                               : {{(WIDTH-1){1'b0}}, rem_shift};
            mag_a_step = {mag_a[2*WIDTH-2:0], q_bit};
            mag_b_step = mag_b;
        end else begin
            acc_step   = mag_b[0] ? acc + mag_a : acc;
            mag_a_step = {mag_a[2*WIDTH-2:0], 1'b0};
            mag_b_step = mag_b >> 1;
        end
        product  = apply_sign(acc_step, neg);
        quotient = neg ? -mag_a_step[WIDTH-1:0] : mag_a_step[WIDTH-1:0];
    end

`ifdef MULTDIV_EARLY_OUT_EN
    assign last_iter = (count == CNT_W'(WIDTH-1)) || (!is_div && mag_b_step == '0);
`else
    assign last_iter = (count == CNT_W'(WIDTH-1));
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next   = state;
        stall        = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                if (take) begin
                    stall      = 1'b1;
                    state_next = div_zero ? DONE : ITER;
                end
            end
            ITER: begin
                stall = 1'b1;
                busy  = 1'b1;
                if (flush)          state_next = IDLE;
                else if (last_iter) state_next = DONE;
            end
            DONE: begin
                busy         = 1'b1;
                result_valid = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count      <= '0;
            acc        <= '0;
            mag_a      <= '0;
            mag_b      <= '0;
            neg        <= 1'b0;
            is_div     <= 1'b0;
            div_ovf    <= 1'b0;
            dest_q     <= '0;
            result     <= '0;
            result_reg <= '0;
            exception  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        count   <= '0;
                        acc     <= '0;
                        mag_a   <= {{WIDTH{1'b0}}, magnitude(operandA)};
                        mag_b   <= magnitude(operandB);
                        neg     <= operandA[WIDTH-1] ^ operandB[WIDTH-1];
                        is_div  <= !start_mult;
                        div_ovf <= (operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (operandB == '1);
                        dest_q  <= dest_reg;
                        if (div_zero) begin
                            result     <= '0;
                            exception  <= 1'b1;
                            result_reg <= dest_reg;
                        end
                    end
                end
                ITER: begin
                    if (!flush) begin
                        count <= count + CNT_W'(1);
                        acc   <= acc_step;
                        mag_a <= mag_a_step;
                        mag_b <= mag_b_step;
                        if (last_iter) begin
                            result_reg <= dest_q;
                            if (is_div) begin
                                result    <= quotient;
                                exception <= div_ovf;
                            end else begin
                                result    <= product[WIDTH-1:0];
                                exception <= mult_ovf(product);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: directed cases plus random mul/div against an arithmetic reference.
module tb_multdiv_ctrl;

    logic        clock;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic        flush;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic [4:0]  dest_reg;
    logic        stall;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;
    logic [4:0]  result_reg;
    logic        exception;

    int checks = 0;
    int errors = 0;

    multdiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clock(clock), .reset(reset), .start_mult(start_mult), .start_div(start_div),
        .flush(flush), .operandA(operandA), .operandB(operandB), .dest_reg(dest_reg),
        .stall(stall), .busy(busy), .result_valid(result_valid), .result(result),
        .result_reg(result_reg), .exception(exception)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference arithmetic: full-precision signed product, truncating signed quotient.
    task automatic model(input bit dv, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic e);
        longint p;
        int     q;
        if (!dv) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p != longint'($signed(p[31:0])));
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            q = $signed(a) / $signed(b);
            r = q;
            e = 1'b0;
        end
    endtask

    // Edges after the issue edge until the result pulse is visible.
    function automatic int exp_lat(input bit dv, input logic [31:0] b);
`ifdef MULTDIV_EARLY_OUT_EN
        int          hi;
        logic [31:0] mb;
`endif
        if (dv && b == 32'd0) return 0;
`ifdef MULTDIV_EARLY_OUT_EN
        if (!dv) begin
            hi = 0;
            mb = b[31] ? -b : b;
            for (int i = 0; i < 32; i++) if (mb[i]) hi = i;
            return hi + 1;
        end
`endif
        return 32;
    endfunction

    task automatic issue(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] dst, input string tag);
        start_mult = m;
        start_div  = d;
        operandA   = a;
        operandB   = b;
        dest_reg   = dst;
        #1;
        chk({tag, " stall_on_issue"}, stall, 1'b1);
        @(posedge clock);
        #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        operandA   = $urandom;
        operandB   = $urandom;
        dest_reg   = 5'd0;
    endtask

    task automatic await_result(input bit dv, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] dst, input string tag);
        int          cyc;
        int          st;
        int          lat;
        logic [31:0] er;
        logic        ee;
        cyc = 0;
        st  = 0;
        lat = exp_lat(dv, b);
        model(dv, a, b, er, ee);
        while (!result_valid && cyc < 100) begin
            if (stall) st++;
            step();
            cyc++;
        end
        chk({tag, " latency"}, cyc, lat);
        chk({tag, " stall_cycles"}, st, lat);
        chk({tag, " result"}, result, er);
        chk({tag, " exception"}, exception, ee);
        chk({tag, " result_reg"}, result_reg, dst);
        chk({tag, " busy_done"}, busy, 1'b1);
        chk({tag, " stall_done"}, stall, 1'b0);
        step();
        chk({tag, " pulse_one_cycle"}, result_valid, 1'b0);
        chk({tag, " result_hold"}, result, er);
        chk({tag, " busy_idle"}, busy, 1'b0);
    endtask

    task automatic run_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] dst, input string tag);
        issue(m, d, a, b, dst, tag);
        await_result(d && !m, a, b, dst, tag);
    endtask

    initial begin
        int          seen;
        logic [31:0] held;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          rd;

        reset      = 1'b0;
        start_mult = 1'b0;
        start_div  = 1'b0;
        flush      = 1'b0;
        operandA   = 32'd0;
        operandB   = 32'd0;
        dest_reg   = 5'd0;
        #2;
        chk("reset result_valid", result_valid, 1'b0);
        chk("reset stall", stall, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset result", result, 32'd0);
        chk("reset result_reg", result_reg, 5'd0);
        chk("reset exception", exception, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        step();

        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 5'd5, "mul_7_m3");
        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd9, "div_m7_2");
        run_op(1'b0, 1'b1, 32'd100, 32'd7, 5'd10, "div_100_7_b2b");
        run_op(1'b0, 1'b1, 32'd5, 32'd0, 5'd11, "div_by_zero");
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, "div_min_m1");
        run_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd13, "mul_ovf");
        run_op(1'b1, 1'b0, 32'h0000_7FFF, 32'h0000_7FFF, 5'd14, "mul_7fff");
        run_op(1'b1, 1'b1, 32'd6, 32'd2, 5'd15, "mul_div_both");
        run_op(1'b1, 1'b0, 32'd9, 32'd3, 5'd16, "mul_9_3");
        run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0, 5'd17, "mul_by_zero");

        // Flush at ITER cycle 10 must abort without a pulse.
        held = result;
        issue(1'b1, 1'b0, 32'd3, 32'h4000_0000, 5'd20, "flush_iter");
        repeat (10) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush stall", stall, 1'b0);
        chk("flush busy", busy, 1'b0);
        chk("flush result_valid", result_valid, 1'b0);
        seen = 0;
        repeat (40) begin
            step();
            if (result_valid) seen++;
        end
        chk("flush no_pulse", seen, 0);
        chk("flush result_hold", result, held);

        // Flush together with a start in IDLE suppresses the capture.
        start_mult = 1'b1;
        operandA   = 32'd4;
        operandB   = 32'd4;
        flush      = 1'b1;
        #1;
        chk("flush_start stall", stall, 1'b0);
        step();
        start_mult = 1'b0;
        flush      = 1'b0;
        chk("flush_start busy", busy, 1'b0);
        chk("flush_start stall_after", stall, 1'b0);

        // Asynchronous reset in the middle of an operation.
        issue(1'b1, 1'b0, 32'd21, 32'hC000_0000, 5'd21, "reset_iter");
        repeat (5) step();
        #2;
        reset = 1'b0;
        #1;
        chk("midreset stall", stall, 1'b0);
        chk("midreset busy", busy, 1'b0);
        chk("midreset result_valid", result_valid, 1'b0);
        chk("midreset result", result, 32'd0);
        chk("midreset result_reg", result_reg, 5'd0);
        chk("midreset exception", exception, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        seen = 0;
        repeat (40) begin
            step();
            if (result_valid) seen++;
        end
        chk("midreset no_pulse", seen, 0);

        // Randomized operations against the reference model.
        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 3))
                0:       ra = $urandom;
                1:       ra = 32'($urandom_range(0, 400)) - 32'd200;
                2:       ra = 32'h8000_0000;
                default: ra = 32'($urandom_range(0, 65535));
            endcase
            case ($urandom_range(0, 4))
                0:       rb = $urandom;
                1:       rb = 32'($urandom_range(0, 40)) - 32'd20;
                2:       rb = 32'd0;
                3:       rb = 32'hFFFF_FFFF;
                default: rb = 32'($urandom_range(1, 65535));
            endcase
            rd = $urandom_range(0, 1) == 1;
            run_op(!rd, rd, ra, rb, 5'($urandom_range(0, 31)), $sformatf("rand%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
Multi-cycle multiply/divide sequencer attached to the execute stage of the 5-stage pipelined processor. It captures operands and the destination register when the execute stage issues a mul/div, runs an internal iterative shift-add multiplier or restoring divider, and holds the pipeline stall line while busy. It then presents a one-cycle result pulse with its destination register and exception flag for the writeback path.

Parameters:
WIDTH, 32, operand/result width in bits (iteration count = WIDTH)
CNT_W, 6, iteration counter width (must hold WIDTH)

Ports:
clock  input  1  master clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
start_mult  input  1  issue signed multiply (execute stage, one cycle)
start_div  input  1  issue signed divide (execute stage, one cycle)
flush  input  1  synchronous abort (branch/jump squash of issuing instr)
operandA  input  WIDTH  multiplicand / dividend
operandB  input  WIDTH  multiplier / divisor
dest_reg  input  5  destination register of issuing instruction
stall  output  1  freeze PC, F/D and D/X latches
busy  output  1  unit occupied (ITER or DONE)
result_valid  output  1  one-cycle result pulse
result  output  WIDTH  product low word / quotient
result_reg  output  5  destination register for result
exception  output  1  overflow or divide-by-zero; valid with result_valid

Behaviour:
- Reset (reset=0, async): state IDLE; counter, accumulators, result, result_reg, exception, result_valid, stall, busy all 0.
- FSM states: IDLE, ITER, DONE.
- IDLE: start sampled on rising edge. start_mult and start_div together -> multiply taken, divide dropped. Edge capture: |A|, |B|, result sign, op, dest_reg; counter=0; -> ITER.
- Divide with operandB==0: skip ITER, -> DONE next edge. result=0, exception=1.
- ITER: one iteration per edge, counter+1; at counter==WIDTH-1 the edge moves to DONE. Issue to result_valid latency = WIDTH cycles (32 by default).
- Multiply: 2*WIDTH-bit shift-add on magnitudes, two's-complement negate if signs differ. result = low WIDTH bits. exception=1 if the signed 2*WIDTH product is not the sign-extension of its low word.
- Divide: restoring divide on magnitudes. Quotient truncates toward zero and is negated if signs differ; remainder discarded. Special case 0x80000000 / -1: result 0x80000000, exception=1.
- DONE: result_valid=1 for exactly one cycle, with result, result_reg and exception stable; next edge -> IDLE.
- result, result_reg and exception hold their value after the pulse until the next DONE.
- stall (combinational) = (state IDLE & (start_mult|start_div) & ~flush) | state ITER. stall is low in DONE, so the pipeline advances in the same cycle the result is presented.
- busy = state ITER or DONE.
- Start asserted while not IDLE: ignored. Issuer must not raise start while stall=1.
- flush: any state -> IDLE on next edge, no result_valid. A flush coincident with start in IDLE suppresses the capture. Flush in DONE cancels nothing, because the pulse is already presented.
- Reset mid-operation: immediate abort to IDLE; no pulse is ever produced for the aborted op.

Optional Feature:
MULTDIV_EARLY_OUT_EN
- Defined: during a multiply, when the remaining unshifted multiplier bits are all zero, ITER goes to DONE on the next edge. Latency = 1 + index of highest set bit of |B| (minimum 1 for B==0). The result is identical to the full run. Divide is unaffected.
- Undefined: every multiply takes exactly WIDTH iteration cycles.

Test Plan:
- mult 7 * -3 (0xFFFFFFFD) -> stall high 32 cycles; result_valid exactly 32 cycles after issue edge; result 0xFFFFFFEB; exception 0; result_reg = dest_reg 5.
- div -7 / 2 -> result 0xFFFFFFFD (-3), exception 0; then div 100 / 7 -> 14; back-to-back issue on the cycle stall drops is accepted.
- div 5 / 0 -> result_valid one cycle after issue; result 0; exception 1. div 0x80000000 / 0xFFFFFFFF -> result 0x80000000, exception 1.
- mult 0x00010000 * 0x00010000 -> result 0x00000000, exception 1. mult 0x7FFF * 0x7FFF -> 0x3FFF0001, exception 0.
- flush at ITER cycle 10 -> IDLE next edge, no result_valid, stall low. Reset pulse at ITER cycle 5 -> all outputs 0 immediately. Simultaneous start_mult & start_div (6, 2) -> result 12.
- With MULTDIV_EARLY_OUT_EN: mult 9 * 3 -> result 27 after 2 cycles. Without the macro: same product after 32 cycles.
